// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the post-reset sequencer / timebase.
// Holds the FSM state encoding and the width defaults used by every block.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    HALT   = 2'd3
  } seq_state_t;

  localparam int CNT_W_DEF = 32;
  localparam int DLY_W     = 8;

  // Terminal value of the settle counter for a given delay (legal range 1..255).
  function automatic logic [DLY_W-1:0] dly_last(input int dly_cycles);
    return DLY_W'(dly_cycles - 1);
  endfunction

endpackage

// File: rtl/ts_hold_reg.sv
// One-entry timestamp buffer on a valid/ready output with sticky drop detection.
// A new load is taken when the slot is empty or is being drained on the same edge.
module ts_hold_reg
  import rst_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             ts_ready,
  output logic             ts_valid,
  output logic [CNT_W-1:0] ts_data,
  output logic             ts_ovf
);

  logic fire;
  logic slot_free;

  assign fire      = ts_valid & ts_ready;
  assign slot_free = ~ts_valid | fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_valid <= 1'b0;
      ts_data  <= '0;
      ts_ovf   <= 1'b0;
    end else begin
      if (load && slot_free) begin
        ts_valid <= 1'b1;
        ts_data  <= load_val;
      end else if (load) begin
        // Buffer full and not draining: keep the held value, flag the loss.
        ts_ovf   <= 1'b1;
      end else if (fire) begin
        ts_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rst_seq_timer.sv
// Post-reset sequencer and cycle timebase: settle delay, run/halt control,
// free-running cycle counter and a handshaked capture timestamp.
module rst_seq_timer
  import rst_seq_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DLY_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             capture,
  input  logic             ts_ready,
  output logic             ready,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             ts_valid,
  output logic [CNT_W-1:0] ts_data,
  output logic             ts_ovf,
  output logic             cnt_wrap
);

  localparam logic [DLY_W-1:0] DLY_LAST = dly_last(DLY_CYCLES);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [DLY_W-1:0] dly_cnt;
  logic [DLY_W-1:0] dly_nxt;
  logic             cnt_en;
  logic             cap_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // The release edge (RESET -> SETTLE) already counts, so cycle_cnt reads the
  // number of edges since reset release.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    cnt_en    = 1'b0;
    unique case (state)
      RESET: begin
        state_nxt = SETTLE;
        dly_nxt   = '0;
        cnt_en    = 1'b1;
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (dly_cnt == DLY_LAST) begin
          state_nxt = RUN;
        end else begin
          dly_nxt = dly_cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (halt_req) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        if (resume_req) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_cnt   <= '0;
      cycle_cnt <= '0;
      cnt_wrap  <= 1'b0;
      ready     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      dly_cnt <= dly_nxt;
      ready   <= (state_nxt == RUN);
      halted  <= (state_nxt == HALT);
      if (cnt_en) begin
        cycle_cnt <= cycle_cnt + 1'b1;
        if (&cycle_cnt) begin
          cnt_wrap <= 1'b1;
        end
      end
    end
  end

  // Captures are only meaningful once the timebase is running; the stamp is
  // the counter value before this edge's increment.
  assign cap_accept = capture & (state == RUN);

  ts_hold_reg #(
    .CNT_W(CNT_W)
  ) u_ts_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (cap_accept),
    .load_val (cycle_cnt),
    .ts_ready (ts_ready),
    .ts_valid (ts_valid),
    .ts_data  (ts_data),
    .ts_ovf   (ts_ovf)
  );

endmodule
